nibble_deserializer: RTL and testbench

NIBBLE_DESERIALIZER -- requirements
Module: nibble_deserializer

---
 rtl/nibble_deserializer_pkg.sv | 19 +
 rtl/wrap_counter_8.sv | 29 ++
 rtl/nibble_deserializer.sv | 138 +++++++++++++
 tb/tb_nibble_deserializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_deserializer_pkg.sv
// Shared types and constants for the nibble deserializer: FSM state encoding,
// nibble width and the parity helper.
package nibble_deserializer_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    LOAD   = 2'd3
  } state_e;

  // XOR of all data bits; an even-parity bit must equal this value.
  function automatic logic nibble_xor(input logic [NIBBLE_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/wrap_counter_8.sv
// 8-bit synchronous counter with increment enable; wraps from 255 to 0.
module wrap_counter_8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  output logic [7:0] count_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/nibble_deserializer.sv
// Serial-to-nibble deserializer: assembles 4 LSB-first bits (plus optional even
// parity) into a nibble and strobes it into a downstream 4-bit register.
//
// Handshake: bit_in and sof are sampled only on rising edges where bit_valid=1;
// there is no backpressure. load/enable form a single-cycle strobe during which
// data already holds the new nibble; data is stable whenever load is 0.
module nibble_deserializer
  import nibble_deserializer_pkg::*;
#(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bit_valid,
  input  logic                bit_in,
  input  logic                sof,
  output logic [NIBBLE_W-1:0] data,
  output logic                load,
  output logic                enable,
  output logic                busy,
  output logic                parity_err,
  output logic                frame_err,
  output logic [7:0]          nibble_count,
  output state_e              dbg_state
);

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [NIBBLE_W-1:0] shift_q, shift_d;
  logic [NIBBLE_W-1:0] data_q, data_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                in_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      shift_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bit_valid && sof) begin
          shift_d = {{(NIBBLE_W-1){1'b0}}, bit_in};
          idx_d   = 2'd1;
          state_d = DATA;
        end
      end

      DATA: begin
        if (bit_valid) begin
          if (sof) begin
            ferr_d  = 1'b1;
            shift_d = {{(NIBBLE_W-1){1'b0}}, bit_in};
            idx_d   = 2'd1;
          end else begin
            shift_d[idx_q] = bit_in;
            // idx wraps 3 -> 0 naturally once the last data bit is stored.
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (PARITY_EN) begin
                state_d = PARITY;
              end else begin
                state_d = LOAD;
                data_d  = shift_d;
              end
            end
          end
        end
      end

      PARITY: begin
        if (bit_valid) begin
          if (sof) begin
            ferr_d  = 1'b1;
            shift_d = {{(NIBBLE_W-1){1'b0}}, bit_in};
            idx_d   = 2'd1;
            state_d = DATA;
          end else if (bit_in == nibble_xor(shift_q)) begin
            state_d = LOAD;
            data_d  = shift_q;
          end else begin
            perr_d  = 1'b1;
            idx_d   = 2'd0;
            state_d = IDLE;
          end
        end
      end

      LOAD: begin
        idx_d   = 2'd0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_load = (state_q == LOAD);

  wrap_counter_8 u_wrap_counter_8 (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (in_load),
    .count_o (nibble_count)
  );

  assign data       = data_q;
  assign load       = in_load;
  assign enable     = in_load;
  assign busy       = (state_q == DATA) || (state_q == PARITY);
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Bench for nibble_deserializer: a PARITY_EN=0 and a PARITY_EN=1 instance share
// one stimulus stream and are each checked every cycle against a frame model.
module tb_nibble_deserializer;
  import nibble_deserializer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;
  logic sof = 1'b0;

  logic [3:0] dut_data [2];
  logic       dut_load [2];
  logic       dut_enable [2];
  logic       dut_busy [2];
  logic       dut_perr [2];
  logic       dut_ferr [2];
  logic [7:0] dut_count [2];
  state_e     dut_state [2];

  nibble_deserializer #(.PARITY_EN(1'b0)) u_dut_p0 (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
    .data(dut_data[0]), .load(dut_load[0]), .enable(dut_enable[0]), .busy(dut_busy[0]),
    .parity_err(dut_perr[0]), .frame_err(dut_ferr[0]), .nibble_count(dut_count[0]),
    .dbg_state(dut_state[0])
  );

  nibble_deserializer #(.PARITY_EN(1'b1)) u_dut_p1 (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
    .data(dut_data[1]), .load(dut_load[1]), .enable(dut_enable[1]), .busy(dut_busy[1]),
    .parity_err(dut_perr[1]), .frame_err(dut_ferr[1]), .nibble_count(dut_count[1]),
    .dbg_state(dut_state[1])
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;
  int ld_cnt [2];
  int perr_cnt [2];
  int ferr_cnt [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural frame model ----------------
  // Index k: 0 = no parity, 1 = even parity. m_cnt counts bits of the frame in
  // progress (0 = no frame); a frame is complete after 4+k bits.
  int         m_cnt [2];
  logic [4:0] m_vec [2];
  bit         m_loading [2];
  logic [3:0] m_data [2];
  logic [7:0] m_count [2];
  bit         m_perr [2];
  bit         m_ferr [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_cnt[k] = 0; m_vec[k] = '0; m_loading[k] = 0; m_data[k] = '0;
        m_count[k] = '0; m_perr[k] = 0; m_ferr[k] = 0;
      end else begin
        m_perr[k] = 0;
        m_ferr[k] = 0;
        if (m_loading[k]) begin
          m_loading[k] = 0;
          m_count[k] = m_count[k] + 8'd1;
        end else if (bit_valid) begin
          if (sof) begin
            m_ferr[k] = (m_cnt[k] != 0);
            m_vec[k] = {4'b0, bit_in};
            m_cnt[k] = 1;
          end else if (m_cnt[k] != 0) begin
            m_vec[k][m_cnt[k]] = bit_in;
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == 4 + k) begin
              // even parity: all five bits together must have an even count of ones
              if (k == 1 && (^m_vec[k]) != 1'b0) begin
                m_perr[k] = 1;
              end else begin
                m_data[k] = m_vec[k][3:0];
                m_loading[k] = 1;
              end
              m_cnt[k] = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("p%0d data", k),   {28'b0, dut_data[k]}, {28'b0, m_data[k]});
        check($sformatf("p%0d load", k),   {31'b0, dut_load[k]}, {31'b0, m_loading[k]});
        check($sformatf("p%0d enable", k), {31'b0, dut_enable[k]}, {31'b0, m_loading[k]});
        check($sformatf("p%0d busy", k),   {31'b0, dut_busy[k]}, {31'b0, (m_cnt[k] != 0)});
        check($sformatf("p%0d parity_err", k), {31'b0, dut_perr[k]}, {31'b0, m_perr[k]});
        check($sformatf("p%0d frame_err", k),  {31'b0, dut_ferr[k]}, {31'b0, m_ferr[k]});
        check($sformatf("p%0d nibble_count", k), {24'b0, dut_count[k]}, {24'b0, m_count[k]});
        if (dut_load[k] === 1'b1) ld_cnt[k]++;
        if (dut_perr[k] === 1'b1) perr_cnt[k]++;
        if (dut_ferr[k] === 1'b1) ferr_cnt[k]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      ld_cnt[k] = 0; perr_cnt[k] = 0; ferr_cnt[k] = 0;
    end
  endtask

  task automatic cyc_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in = 1'($urandom_range(0, 1));
      sof = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in = b;
    sof = s;
  endtask

  task automatic send_frame(input logic [3:0] nib, input logic par, input bit with_par, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (gap > 0) cyc_idle(gap);
      send_bit(nib[i], (i == 0));
    end
    if (with_par) begin
      if (gap > 0) cyc_idle(gap);
      send_bit(par, 1'b0);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    bit_valid = 1'b0;
    sof = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    do_reset(2);
    check("reset data", {28'b0, dut_data[1]}, 32'h0);
    check("reset count", {24'b0, dut_count[1]}, 32'h0);

    // Good frame 1,0,1,1 with parity 1.
    clear_counts();
    send_frame(4'b1101, 1'b1, 1'b1, 0);
    cyc_idle(3);
    check("good frame data", {28'b0, dut_data[1]}, 32'hD);
    check("good frame count", {24'b0, dut_count[1]}, 32'h1);
    check("good frame loads", ld_cnt[1], 32'd1);
    check("good frame perr", perr_cnt[1], 32'd0);

    // Same frame with wrong parity.
    do_reset(2);
    clear_counts();
    send_frame(4'b1101, 1'b0, 1'b1, 0);
    cyc_idle(3);
    check("bad parity perr", perr_cnt[1], 32'd1);
    check("bad parity loads", ld_cnt[1], 32'd0);
    check("bad parity data", {28'b0, dut_data[1]}, 32'h0);

    // Aborted frame followed by 0,1,1,0 parity 0.
    do_reset(2);
    clear_counts();
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1, 0);
    cyc_idle(3);
    check("abort ferr", ferr_cnt[1], 32'd1);
    check("abort loads", ld_cnt[1], 32'd1);
    check("abort data", {28'b0, dut_data[1]}, 32'h6);

    // Reset after the third bit, then 1,1,1,1 parity 0.
    do_reset(2);
    clear_counts();
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bit_valid = 1'b0;
    @(negedge clk);
    check("midreset busy", {31'b0, dut_busy[1]}, 32'h0);
    check("midreset load", {31'b0, dut_load[1]}, 32'h0);
    check("midreset perr", {31'b0, dut_perr[1]}, 32'h0);
    check("midreset ferr", {31'b0, dut_ferr[1]}, 32'h0);
    reset = 1'b0;
    send_frame(4'b1111, 1'b0, 1'b1, 0);
    cyc_idle(3);
    check("after reset data", {28'b0, dut_data[1]}, 32'hF);
    check("after reset loads", ld_cnt[1], 32'd1);

    // Gapped frame 1,0,0,0 parity 1; load exactly one cycle after the parity bit.
    do_reset(2);
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      cyc_idle(3);
      send_bit((i == 0), (i == 0));
    end
    cyc_idle(3);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    check("gapped load timing", {31'b0, dut_load[1]}, 32'h1);
    cyc_idle(3);
    check("gapped data", {28'b0, dut_data[1]}, 32'h1);
    check("gapped loads", ld_cnt[1], 32'd1);

    // 256 parity-free frames: the counter must wrap to zero.
    do_reset(2);
    clear_counts();
    repeat (256) begin
      send_frame(4'($urandom_range(0, 15)), 1'b0, 1'b0, 0);
      cyc_idle($urandom_range(1, 3));
    end
    cyc_idle(2);
    check("wrap loads", ld_cnt[0], 32'd256);
    check("wrap count", {24'b0, dut_count[0]}, 32'h0);

    // Random traffic, occasional resets.
    do_reset(1);
    repeat (1500) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset(1);
      else if (r < 60) send_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      else cyc_idle(1);
    end
    cyc_idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
